mem_port_scheduler: RTL and testbench
=====================================

// Module: mem_port_scheduler
// PURPOSE
//  Registered scheduler for the single shared memory port. Arbitrates between instruction-fetch
//  line refills (fetch cache) and data line reads/writes (tlblookup stage) and issues one
//  transaction at a time. Data requests have priority; a starvation counter bounds fetch waiting.
//  Sits between the fetch cache / tlblookup stage and the memory, and replaces the combinational arbiter.
// PARAMETERS
//  addr_width      16   memory address width
//  starve_limit    4    consecutive data grants allowed while an instr petition waits (>=1)
//  timeout_cycles  64   cycles in a busy state without serviceReady before timeoutErr sets (>=2)
// PORTS
//  clk               in   1           clock, rising edge
//  reset             in   1           asynchronous, active-high
//  petitionInstr     in   1           fetch-cache refill request, level, held until served
//  addressInstr      in   addr_width  fetch refill line address
//  petitionDat       in   1           tlblookup data request, level, held until served
//  addressDat        in   addr_width  data line address
//  weDat             in   1           1 = data write-back, 0 = data line read
//  serviceReady      in   1           memory completion, 1-cycle pulse
//  petitionMem       out  1           request to memory
//  addressMem        out  addr_width  registered address to memory
//  weMem             out  1           registered write enable to memory
//  serviceReadyInstr out  1           completion to fetch cache
//  serviceReadyDat   out  1           completion to tlblookup
//  busy              out  1           high in any state other than IDLE
//  timeoutErr        out  1           sticky; cleared only by reset
// BEHAVIOUR
//  Reset (async): state=IDLE. petitionMem, addressMem, weMem, busy, timeoutErr, starveCnt and
//   waitCnt all go to 0. serviceReady* = 0. An in-flight transaction is abandoned, with no replay.
//  States: IDLE, INSTR_BUSY, DAT_BUSY, GAP.
//  IDLE: sample petitions at the clock edge.
//   - Only petitionDat -> DAT_BUSY.
//   - Only petitionInstr -> INSTR_BUSY.
//   - Both: INSTR_BUSY if starveCnt==starve_limit, else DAT_BUSY.
//   - Neither: stay in IDLE.
//   On the granting edge, latch addressMem/weMem from the winner. weMem=0 for instr grants.
//  INSTR_BUSY / DAT_BUSY:
//   - petitionMem=1. addressMem/weMem hold stable until exit, regardless of input changes.
//   - serviceReadyInstr = serviceReady & (state==INSTR_BUSY), combinational, same cycle.
//   - serviceReadyDat   = serviceReady & (state==DAT_BUSY),   combinational, same cycle.
//   - On serviceReady -> GAP.
//  GAP: exactly 1 cycle. petitionMem=0 and petitions are ignored; the served requester drops
//   its petition here. Then -> IDLE.
//  Latency: request seen at edge N -> petitionMem high from cycle N+1.
//   Back-to-back grants are spaced by at least 2 idle-port cycles (GAP + IDLE).
//  Starvation counter (width clog2(starve_limit+1)), updated on grant edges only:
//   - Data grant with petitionInstr high: +1, saturating at starve_limit.
//   - Instr grant, or data grant with petitionInstr low: cleared to 0.
//  Timeout: waitCnt counts cycles spent in *_BUSY and is cleared on entry to a busy state.
//   When waitCnt reaches timeout_cycles-1 without serviceReady, timeoutErr sets.
//   The FSM keeps waiting; it never aborts.
//  Stray serviceReady in IDLE or GAP: ignored, with no serviceReady* output.
//  A requester dropping its petition mid-transaction does not cancel the transaction.
// TESTING
//  1 Reset mid-DAT_BUSY (addressMem=0x0140) -> all outputs 0 immediately. First grant after
//    release starts cleanly.
//  2 Instr only, addressInstr=0x020c; mem replies after 3 cycles -> petitionMem high 1 cycle
//    after request; serviceReadyInstr pulses with serviceReady; weMem=0.
//  3 Both petitions at the same edge, starveCnt=0, weDat=1, addressDat=0x0080 -> DAT_BUSY,
//    weMem=1, addressMem=0x0080. After GAP+IDLE -> INSTR_BUSY.
//  4 Data re-requests continuously with instr held, starve_limit=4 -> 4 data grants, 5th grant
//    instr, then starveCnt=0.
//  5 No serviceReady for 64 cycles in INSTR_BUSY -> timeoutErr=1 and stays 1. A later
//    serviceReady still completes the transaction.
//  6 serviceReady pulsed in IDLE and in GAP -> no serviceReadyInstr/Dat, state unchanged.

Source files
------------

// File: rtl/mem_port_scheduler_if.sv
// Signal bundle between the fetch cache / tlblookup requesters, the memory port
// and the scheduler. The scheduler connects through the slave modport.
interface mem_port_scheduler_if #(
    parameter int addr_width = 16
);
    logic                  petitionInstr;
    logic [addr_width-1:0] addressInstr;
    logic                  petitionDat;
    logic [addr_width-1:0] addressDat;
    logic                  weDat;
    logic                  serviceReady;
    logic                  petitionMem;
    logic [addr_width-1:0] addressMem;
    logic                  weMem;
    logic                  serviceReadyInstr;
    logic                  serviceReadyDat;
    logic                  busy;
    logic                  timeoutErr;

    modport master (
        output petitionInstr, addressInstr, petitionDat, addressDat, weDat, serviceReady,
        input  petitionMem, addressMem, weMem, serviceReadyInstr, serviceReadyDat,
               busy, timeoutErr
    );

    modport slave (
        input  petitionInstr, addressInstr, petitionDat, addressDat, weDat, serviceReady,
        output petitionMem, addressMem, weMem, serviceReadyInstr, serviceReadyDat,
               busy, timeoutErr
    );
endinterface

// File: rtl/mem_port_scheduler.sv
// Registered scheduler for the single shared memory port: data requests win,
// but a bounded number of consecutive data grants keeps fetch refills from starving.
module mem_port_scheduler #(
    parameter int addr_width     = 16,
    parameter int starve_limit   = 4,
    parameter int timeout_cycles = 64
) (
    input logic               clk,
    input logic               reset,
    mem_port_scheduler_if.slave bus
);
    localparam int STARVE_W = $clog2(starve_limit + 1);
    localparam int WAIT_W   = $clog2(timeout_cycles);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(starve_limit);
    localparam logic [WAIT_W-1:0]   WAIT_MAX   = WAIT_W'(timeout_cycles - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] INSTR_BUSY = 2'd1;
    localparam logic [1:0] DAT_BUSY   = 2'd2;
    localparam logic [1:0] GAP        = 2'd3;

    logic [1:0]            r_state;
    logic [addr_width-1:0] r_addressMem;
    logic                  r_weMem;
    logic                  r_timeoutErr;
    logic [STARVE_W-1:0]   r_starveCnt;
    logic [WAIT_W-1:0]     r_waitCnt;

    logic w_busyState;
    logic w_instrWins;
    logic w_datWins;

    // Instr only wins a contested grant once data has used up its starvation allowance.
    assign w_busyState = (r_state == INSTR_BUSY) || (r_state == DAT_BUSY);
    assign w_instrWins = bus.petitionInstr && (!bus.petitionDat || (r_starveCnt == STARVE_MAX));
    assign w_datWins   = bus.petitionDat && !w_instrWins;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addressMem <= '0;
            r_weMem      <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_starveCnt  <= '0;
            r_waitCnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_instrWins) begin
                        r_state      <= INSTR_BUSY;
                        r_addressMem <= bus.addressInstr;
                        r_weMem      <= 1'b0;
                        r_starveCnt  <= '0;
                        r_waitCnt    <= '0;
                    end else if (w_datWins) begin
                        r_state      <= DAT_BUSY;
                        r_addressMem <= bus.addressDat;
                        r_weMem      <= bus.weDat;
                        r_waitCnt    <= '0;
                        if (!bus.petitionInstr) begin
                            r_starveCnt <= '0;
                        end else if (r_starveCnt != STARVE_MAX) begin
                            r_starveCnt <= r_starveCnt + STARVE_W'(1);
                        end
                    end
                end
                INSTR_BUSY, DAT_BUSY: begin
                    // The wait counter parks at its limit; the transaction is never aborted.
                    if (bus.serviceReady) begin
                        r_state <= GAP;
                    end else if (r_waitCnt == WAIT_MAX) begin
                        r_timeoutErr <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.petitionMem       = w_busyState;
    assign bus.addressMem        = r_addressMem;
    assign bus.weMem             = r_weMem;
    assign bus.serviceReadyInstr = bus.serviceReady && (r_state == INSTR_BUSY);
    assign bus.serviceReadyDat   = bus.serviceReady && (r_state == DAT_BUSY);
    assign bus.busy              = (r_state != IDLE);
    assign bus.timeoutErr        = r_timeoutErr;
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Randomized requester/memory agents drive the scheduler; a transaction-level
// reference model feeds a scoreboard queue that a separate monitor drains.
module tb_mem_port_scheduler;
    localparam int AW      = 16;
    localparam int STARVE  = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
    } txn_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_port_scheduler_if #(.addr_width(AW)) bus();

    mem_port_scheduler #(
        .addr_width(AW),
        .starve_limit(STARVE),
        .timeout_cycles(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checksTotal  = 0;
    int checksPassed = 0;

    // Reference model: who owns the port, how long it has waited, data streak length.
    int   mOwner     = 0;
    bit   mGap       = 1'b0;
    int   busyCycles = 0;
    int   datStreak  = 0;
    bit   mTimeout   = 1'b0;
    txn_t expQ[$];

    bit memHold   = 1'b0;
    bit strayEn   = 1'b0;
    bit instrEn   = 1'b0;
    bit datEn     = 1'b0;
    bit instrCont = 1'b0;
    bit datCont   = 1'b0;
    bit dropInstr = 1'b0;
    bit dropDat   = 1'b0;
    int memWait   = -1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model steps on the same edges as the DUT, from the inputs alone.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mOwner = 0; mGap = 1'b0; busyCycles = 0; datStreak = 0; mTimeout = 1'b0;
                expQ.delete();
            end else if (mOwner != 0) begin
                busyCycles++;
                if (bus.serviceReady) begin
                    mOwner = 0;
                    mGap   = 1'b1;
                end else if (busyCycles >= TIMEOUT) begin
                    mTimeout = 1'b1;
                end
            end else if (mGap) begin
                mGap = 1'b0;
            end else if (bus.petitionInstr || bus.petitionDat) begin
                busyCycles = 0;
                if (bus.petitionInstr && (!bus.petitionDat || datStreak == STARVE)) begin
                    expQ.push_back('{addr: bus.addressInstr, we: 1'b0});
                    mOwner    = 1;
                    datStreak = 0;
                end else begin
                    expQ.push_back('{addr: bus.addressDat, we: bus.weDat});
                    mOwner    = 2;
                    datStreak = bus.petitionInstr ? ((datStreak < STARVE) ? datStreak + 1 : STARVE) : 0;
                end
            end
        end
    end

    // Monitor samples just before each rising edge, pops on every new transaction.
    initial begin
        txn_t cur;
        bit   prevPet;
        cur     = '0;
        prevPet = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (bus.petitionMem && !prevPet) begin
                checkOutput("grantQueued", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    cur = expQ.pop_front();
                    checkOutput("grantAddr", 32'(bus.addressMem), 32'(cur.addr));
                    checkOutput("grantWe", 32'(bus.weMem), 32'(cur.we));
                end
            end else if (bus.petitionMem) begin
                checkOutput("addrHold", {15'd0, bus.weMem, bus.addressMem}, {15'd0, cur.we, cur.addr});
            end
            prevPet = bus.petitionMem;
            checkOutput("petitionMem", 32'(bus.petitionMem), 32'(mOwner != 0));
            checkOutput("busy", 32'(bus.busy), 32'((mOwner != 0) || mGap));
            checkOutput("serviceReadyInstr", 32'(bus.serviceReadyInstr), 32'(bus.serviceReady && mOwner == 1));
            checkOutput("serviceReadyDat", 32'(bus.serviceReadyDat), 32'(bus.serviceReady && mOwner == 2));
            checkOutput("timeoutErr", 32'(bus.timeoutErr), 32'(mTimeout));
        end
    end

    // One cycle of requester and memory agent behaviour, driven on the falling edge.
    task automatic applyStimulus();
        bit justDropI;
        bit justDropD;
        @(negedge clk);
        justDropI = dropInstr;
        justDropD = dropDat;
        if (dropInstr) bus.petitionInstr = 1'b0;
        if (dropDat) bus.petitionDat = 1'b0;
        dropInstr = 1'b0;
        dropDat   = 1'b0;
        bus.serviceReady = 1'b0;
        if (bus.petitionMem) begin
            if (!memHold) begin
                if (memWait < 0) memWait = $urandom_range(0, 4);
                if (memWait == 0) begin
                    bus.serviceReady = 1'b1;
                    memWait = -1;
                    if (mOwner == 1) dropInstr = 1'b1;
                    else dropDat = 1'b1;
                end else begin
                    memWait--;
                end
            end
        end else if (strayEn && $urandom_range(0, 4) == 0) begin
            bus.serviceReady = 1'b1;
        end
        if (!bus.petitionInstr || mOwner == 1) bus.addressInstr = AW'($urandom);
        if (!bus.petitionDat || mOwner == 2) begin
            bus.addressDat = AW'($urandom);
            bus.weDat      = 1'($urandom);
        end
        if (!bus.petitionInstr && !justDropI && instrEn && (instrCont || $urandom_range(0, 3) == 0))
            bus.petitionInstr = 1'b1;
        if (!bus.petitionDat && !justDropD && datEn && (datCont || $urandom_range(0, 3) == 0))
            bus.petitionDat = 1'b1;
    endtask

    task automatic drainTraffic();
        instrEn = 1'b0; datEn = 1'b0; instrCont = 1'b0; datCont = 1'b0;
        strayEn = 1'b0; memHold = 1'b0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus();
            if (!bus.petitionInstr && !bus.petitionDat && !bus.busy) break;
        end
        checkOutput("drainIdle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.petitionInstr = 1'b0; bus.addressInstr = '0;
        bus.petitionDat   = 1'b0; bus.addressDat   = '0;
        bus.weDat         = 1'b0; bus.serviceReady = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetPetitionMem", 32'(bus.petitionMem), 32'd0);

        $display("[TB] reset in the middle of a data transaction");
        memHold = 1'b1;
        applyStimulus();
        bus.petitionDat = 1'b1; bus.addressDat = 16'h0140; bus.weDat = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            if (bus.petitionMem) break;
        end
        checkOutput("t1PetitionMem", 32'(bus.petitionMem), 32'd1);
        checkOutput("t1AddrBeforeReset", 32'(bus.addressMem), 32'h0140);
        reset = 1'b1;
        #1;
        checkOutput("t1RstPetitionMem", 32'(bus.petitionMem), 32'd0);
        checkOutput("t1RstAddressMem", 32'(bus.addressMem), 32'd0);
        checkOutput("t1RstWeMem", 32'(bus.weMem), 32'd0);
        checkOutput("t1RstBusy", 32'(bus.busy), 32'd0);
        checkOutput("t1RstTimeoutErr", 32'(bus.timeoutErr), 32'd0);
        checkOutput("t1RstSrInstr", 32'(bus.serviceReadyInstr), 32'd0);
        checkOutput("t1RstSrDat", 32'(bus.serviceReadyDat), 32'd0);
        memWait = -1; dropDat = 1'b0; dropInstr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        memHold = 1'b0;
        repeat (12) applyStimulus();
        drainTraffic();

        $display("[TB] instruction refill only");
        applyStimulus();
        bus.petitionInstr = 1'b1; bus.addressInstr = 16'h020c;
        repeat (12) applyStimulus();
        drainTraffic();

        $display("[TB] simultaneous petitions, data write wins");
        applyStimulus();
        bus.petitionInstr = 1'b1; bus.addressInstr = 16'h0404;
        bus.petitionDat = 1'b1; bus.addressDat = 16'h0080; bus.weDat = 1'b1;
        repeat (20) applyStimulus();
        drainTraffic();

        $display("[TB] data re-requests continuously while instr waits");
        applyStimulus();
        bus.petitionInstr = 1'b1;
        bus.petitionDat   = 1'b1;
        datEn = 1'b1; datCont = 1'b1;
        repeat (60) applyStimulus();
        drainTraffic();

        $display("[TB] memory never answers an instr refill");
        memHold = 1'b1;
        applyStimulus();
        bus.petitionInstr = 1'b1; bus.addressInstr = 16'h0333;
        repeat (70) applyStimulus();
        checkOutput("t5TimeoutErr", 32'(bus.timeoutErr), 32'd1);
        checkOutput("t5StillWaiting", 32'(bus.petitionMem), 32'd1);
        memHold = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("t5TimeoutSticky", 32'(bus.timeoutErr), 32'd1);
        drainTraffic();

        $display("[TB] stray completions and random traffic");
        strayEn = 1'b1;
        repeat (20) applyStimulus();
        for (int blk = 0; blk < 12; blk++) begin
            instrEn   = ($urandom_range(0, 3) != 0);
            datEn     = ($urandom_range(0, 3) != 0);
            instrCont = ($urandom_range(0, 3) == 0);
            datCont   = ($urandom_range(0, 2) == 0);
            strayEn   = 1'($urandom);
            repeat (100) applyStimulus();
        end
        drainTraffic();
        repeat (2) applyStimulus();
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
